bram_pixel_writer: RTL

//  Avalon-MM write master driving port s2 of the 64-bit x 1024 dual-port frame BRAM.

---
 rtl/bram_pixel_writer_pkg.sv | 30 +++
 rtl/bram_pixel_writer_packer.sv | 61 ++++++
 rtl/bram_pixel_writer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/bram_pixel_writer_pkg.sv
// Shared constants, FSM state codes and the lane-count to byteenable mapping
// for the frame-BRAM pixel writer.
package bram_pkg;

  localparam int LANES  = 4;
  localparam int WORD_W = 64;
  localparam int BE_W   = 8;
  localparam int LANE_W = 3;

  localparam logic [LANE_W-1:0] LANES_L = 3'd4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  // n filled 16-bit lanes -> the low 2n byte lanes enabled
  function automatic logic [BE_W-1:0] lane_to_be(input logic [LANE_W-1:0] n);
    logic [BE_W-1:0] be;
    case (n)
      3'd0:    be = 8'h00;
      3'd1:    be = 8'h03;
      3'd2:    be = 8'h0F;
      3'd3:    be = 8'h3F;
      3'd4:    be = 8'hFF;
      default: be = 8'hFF;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/bram_pixel_writer_packer.sv
// Lane counter and 64-bit pixel assembly register; pixel 0 lands in the LSBs.
// full is the look-ahead flag: the word will hold all lanes after this cycle.
module pixel_packer
  import bram_pkg::*;
#(
  parameter int PIX_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [PIX_W-1:0]  pix,
  output logic              full,
  output logic [LANE_W-1:0] lane,
  output logic [WORD_W-1:0] word,
  output logic [BE_W-1:0]   be
);

  logic [LANE_W-1:0] lane_q, lane_d, base_lane_s;
  logic [WORD_W-1:0] word_q, word_d;
  logic [BE_W-1:0]   be_q;

  // clear restarts the word at lane 0; a load in the same cycle fills lane 0
  always_comb begin
    lane_d      = lane_q;
    word_d      = word_q;
    base_lane_s = lane_q;
    if (clear) begin
      lane_d      = 3'd0;
      word_d      = '0;
      base_lane_s = 3'd0;
    end else begin
      base_lane_s = lane_q;
    end
    if (load && (base_lane_s < LANES_L)) begin
      word_d[int'(base_lane_s) * PIX_W +: PIX_W] = pix;
      lane_d = base_lane_s + 3'd1;
    end else begin
      lane_d = lane_d;
    end
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= 3'd0;
      word_q <= '0;
      be_q   <= 8'h00;
    end else begin
      lane_q <= lane_d;
      word_q <= word_d;
      be_q   <= lane_to_be(lane_d);
    end
  end

  assign full = (lane_d == LANES_L);
  assign lane = lane_q;
  assign word = word_q;
  assign be   = be_q;

endmodule

// File: rtl/bram_pixel_writer.sv
// Avalon-ST RGB565 sink packing 4 pixels per word and writing each word to the
// frame BRAM through a single-beat Avalon-MM write master.
module bram_pixel_writer
  import bram_pkg::*;
#(
  parameter int                PIX_W     = 16,
  parameter int                ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [PIX_W-1:0]  snk_data,
  input  logic              snk_valid,
  output logic              snk_ready,
  input  logic              snk_sop,
  input  logic              snk_eop,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [WORD_W-1:0] avm_writedata,
  output logic [BE_W-1:0]   avm_byteenable,
  input  logic              avm_waitrequest,
  output logic              frame_done,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W:0] WC_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] WC_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   wc_q, wc_d;
  logic              eop_q, eop_d;
  logic              write_q, write_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;

  logic              beat_s, accept_s;
  logic              pk_load_s, pk_clear_s, pk_full_s;
  logic [LANE_W-1:0] pk_lane_s;
  logic [WORD_W-1:0] pk_word_s;
  logic [BE_W-1:0]   pk_be_s;

  assign beat_s   = snk_valid & ready_q;
  assign accept_s = write_q & ~avm_waitrequest;

  pixel_packer #(.PIX_W(PIX_W)) u_packer (
    .clk   (clk),
    .rst_n (reset_n),
    .load  (pk_load_s),
    .clear (pk_clear_s),
    .pix   (snk_data),
    .full  (pk_full_s),
    .lane  (pk_lane_s),
    .word  (pk_word_s),
    .be    (pk_be_s)
  );

  // frame FSM, address / word counters and next values of the registered outputs
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wc_d       = wc_q;
    eop_d      = eop_q;
    done_d     = 1'b0;
    pk_load_s  = 1'b0;
    pk_clear_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // beats outside a frame are swallowed so the camera never stalls
        if (beat_s && snk_sop) begin
          addr_d     = BASE_ADDR;
          wc_d       = '0;
          pk_clear_s = 1'b1;
          pk_load_s  = 1'b1;
          eop_d      = snk_eop;
          state_d    = snk_eop ? ST_WRITE : ST_FILL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (pk_lane_s >= LANES_L) begin
          pk_clear_s = 1'b1;
          state_d    = ST_IDLE;
        end else if (beat_s) begin
          pk_load_s = 1'b1;
          if (snk_sop) begin
            // a new frame abandons the partial word without writing it
            addr_d     = BASE_ADDR;
            wc_d       = '0;
            pk_clear_s = 1'b1;
          end else begin
            pk_clear_s = 1'b0;
          end
          if (pk_full_s || snk_eop) begin
            eop_d   = snk_eop;
            state_d = ST_WRITE;
          end else begin
            state_d = ST_FILL;
          end
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_WRITE: begin
        if (accept_s) begin
          addr_d     = addr_q + ADDR_W'(1);
          wc_d       = (wc_q == WC_MAX) ? wc_q : (wc_q + WC_ONE);
          pk_clear_s = 1'b1;
          done_d     = eop_q;
          eop_d      = 1'b0;
          state_d    = eop_q ? ST_IDLE : ST_FILL;
        end else begin
          state_d = ST_WRITE;
        end
      end
      default: begin
        pk_clear_s = 1'b1;
        eop_d      = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
    write_d = (state_d == ST_WRITE);
    ready_d = (state_d != ST_WRITE);
  end

  // state and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wc_q    <= '0;
      eop_q   <= 1'b0;
      write_q <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wc_q    <= wc_d;
      eop_q   <= eop_d;
      write_q <= write_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign snk_ready      = ready_q;
  assign avm_address    = addr_q;
  assign avm_write      = write_q;
  assign avm_chipselect = write_q;
  assign avm_writedata  = pk_word_s;
  assign avm_byteenable = pk_be_s;
  assign frame_done     = done_q;
  assign word_count     = wc_q;

endmodule
